// File: rtl/fft_in_loader_if.sv
// Sample stream and FFT-core write bus of the FFT input loader.
// The master modport is the loader's view; slave is the environment's view.
interface fft_in_loader_if #(
  parameter int N = 8,
  parameter int W = 16
);
  localparam int LW = $clog2(N);

  logic                s_valid;
  logic                s_ready;
  logic signed [W-1:0] s_re;
  logic signed [W-1:0] s_im;
  logic                s_last;

  logic                w_en;
  logic [LW-1:0]       idx0;
  logic signed [W-1:0] xr;
  logic signed [W-1:0] xi;

  modport master (
    input  s_valid, s_re, s_im, s_last,
    output s_ready, w_en, idx0, xr, xi
  );

  modport slave (
    output s_valid, s_re, s_im, s_last,
    input  s_ready, w_en, idx0, xr, xi
  );
endinterface

// File: rtl/fft_in_loader.sv
// Ping-pong frame collector that replays each full N-sample frame to the FFT core
// as one N-cycle write burst, then waits GAP cycles and pulses fft_done.
module fft_in_loader #(
  parameter int N   = 8,
  parameter int W   = 16,
  parameter int GAP = 12
) (
  input  logic              clk,
  input  logic              rst,
  fft_in_loader_if.master   bus,
  output logic              busy,
  output logic              fft_done,
  output logic              err
);
  localparam int LW = $clog2(N);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [LW-1:0] IDX_LAST = LW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP} state_t;

  logic [2*W-1:0] r_mem [0:2*N-1];

  logic          r_wb;
  logic [LW-1:0] r_wp;
  logic [1:0]    r_full;
  logic          r_ready;
  logic          r_err;

  state_t          r_state;
  logic            r_rb;
  logic [LW-1:0]   r_idx0;
  logic            r_wen;
  logic [W-1:0]    r_xr;
  logic [W-1:0]    r_xi;
  logic            r_busy;
  logic            r_done;
  logic [GW-1:0]   r_gcnt;

  logic          w_accept;
  logic          w_close;
  logic          w_abort;
  logic          w_clr;
  logic [1:0]    w_full_nxt;
  logic          w_wb_nxt;
  logic [LW-1:0] w_idx_nxt;

  assign w_accept  = bus.s_valid && r_ready;
  assign w_close   = w_accept && (r_wp == IDX_LAST);
  assign w_abort   = w_accept && bus.s_last && (r_wp != IDX_LAST);
  assign w_clr     = (r_state == ST_BURST) && (r_idx0 == IDX_LAST);
  assign w_idx_nxt = r_idx0 + LW'(1);
  assign w_wb_nxt  = w_close ? ~r_wb : r_wb;

  // Clear is applied last so it wins over a fill of the same bank.
  always_comb begin
    w_full_nxt = r_full;
    if (w_close) w_full_nxt[r_wb] = 1'b1;
    if (w_clr)   w_full_nxt[r_rb] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb    <= 1'b0;
      r_wp    <= '0;
      r_full  <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_full  <= w_full_nxt;
      r_wb    <= w_wb_nxt;
      r_ready <= !w_full_nxt[w_wb_nxt];
      r_err   <= w_abort;
      if (w_close || w_abort) r_wp <= '0;
      else if (w_accept)      r_wp <= r_wp + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !w_abort) r_mem[{r_wb, r_wp}] <= {bus.s_re, bus.s_im};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rb    <= 1'b0;
      r_idx0  <= '0;
      r_wen   <= 1'b0;
      r_xr    <= '0;
      r_xi    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gcnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_full[r_rb]) begin
            r_state      <= ST_BURST;
            r_wen        <= 1'b1;
            r_busy       <= 1'b1;
            r_idx0       <= '0;
            {r_xr, r_xi} <= r_mem[{r_rb, {LW{1'b0}}}];
          end
        end
        ST_BURST: begin
          if (r_idx0 == IDX_LAST) begin
            r_state <= ST_GAP;
            r_wen   <= 1'b0;
            r_idx0  <= '0;
            r_xr    <= '0;
            r_xi    <= '0;
            r_rb    <= ~r_rb;
            r_gcnt  <= '0;
            r_done  <= (GAP == 1);
          end else begin
            r_idx0       <= w_idx_nxt;
            {r_xr, r_xi} <= r_mem[{r_rb, w_idx_nxt}];
          end
        end
        ST_GAP: begin
          // fft_done is raised on entry to the final GAP cycle.
          if (r_gcnt == GAP_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gcnt <= r_gcnt + GW'(1);
            r_done <= ((r_gcnt + GW'(1)) == GAP_LAST);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_ready = r_ready;
  assign bus.w_en    = r_wen;
  assign bus.idx0    = r_idx0;
  assign bus.xr      = r_xr;
  assign bus.xi      = r_xi;
  assign busy        = r_busy;
  assign fft_done    = r_done;
  assign err         = r_err;
endmodule

// File: tb/tb_fft_in_loader.sv
// Directed bench for fft_in_loader: N=8/GAP=12 instance plus an N=4/GAP=1 instance.
module tb_fft_in_loader;
  localparam int N   = 8;
  localparam int W   = 16;
  localparam int GAP = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_in_loader_if #(.N(N), .W(W)) ba ();
  fft_in_loader_if #(.N(4), .W(W)) bb ();
  logic busy_a, done_a, err_a;
  logic busy_b, done_b, err_b;

  fft_in_loader #(.N(N), .W(W), .GAP(GAP)) dut_a (
    .clk(clk), .rst(rst), .bus(ba.master),
    .busy(busy_a), .fft_done(done_a), .err(err_a)
  );

  fft_in_loader #(.N(4), .W(W), .GAP(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bb.master),
    .busy(busy_b), .fft_done(done_b), .err(err_b)
  );

  int n_chk  = 0;
  int n_errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  int          cyc = 0;
  logic [31:0] expq [$];
  logic [31:0] pend [$];
  int          starts [$];
  int          exp_idx = 0;
  int          n_done = 0;
  int          n_err_seen = 0;
  int          last_wen_cyc = 0;
  logic        prev_wen = 1'b0;
  logic        prev_done = 1'b0;
  int          acc_cyc = 0;
  int          n_acc = 0;
  int          stall_at = -1;

  always @(posedge clk) cyc++;

  // Output monitor for the N=8 instance: order, continuity, data and fft_done timing.
  always @(negedge clk) begin
    if (rst) begin
      exp_idx   = 0;
      prev_wen  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (ba.w_en) begin
        if (ba.idx0 == 0) starts.push_back(cyc);
        else check("no_bubble", 32'(prev_wen), 1);
        check("idx0", 32'(ba.idx0), exp_idx);
        check("busy_in_burst", 32'(busy_a), 1);
        check("sample_avail", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          logic [31:0] e;
          e = expq.pop_front();
          check("xr", {16'd0, ba.xr}, {16'd0, e[31:16]});
          check("xi", {16'd0, ba.xi}, {16'd0, e[15:0]});
        end
        exp_idx      = (exp_idx + 1) % N;
        last_wen_cyc = cyc;
      end
      if (done_a) begin
        check("done_lat", cyc - last_wen_cyc, GAP);
        check("done_single", 32'(prev_done), 0);
        n_done++;
      end
      if (err_a) n_err_seen++;
      prev_wen  = ba.w_en;
      prev_done = done_a;
    end
  end

  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
    logic acc;
    acc = 1'b0;
    ba.s_valid = 1'b1;
    ba.s_re    = re;
    ba.s_im    = im;
    ba.s_last  = last;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = ba.s_ready;
      @(posedge clk);
      #1;
      if (!acc && stall_at < 0) stall_at = n_acc;
    end
    if (!acc) check("send_timeout", 32'(acc), 1);
    else begin
      n_acc++;
      acc_cyc = cyc;
      pend.push_back({re, im});
      if (pend.size() == N) begin
        foreach (pend[j]) expq.push_back(pend[j]);
        pend.delete();
      end else if (last) begin
        pend.delete();
      end
    end
  endtask

  task automatic idle();
    ba.s_valid = 1'b0;
    ba.s_last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && n_done < target; i++) @(negedge clk);
    @(posedge clk);
    #1;
    check("wait_done", n_done, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d0, e0, nw, nd, lastc;
    logic found;
    logic [15:0] re, im;

    ba.s_valid = 1'b0; ba.s_re = '0; ba.s_im = '0; ba.s_last = 1'b0;
    bb.s_valid = 1'b0; bb.s_re = '0; bb.s_im = '0; bb.s_last = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_w_en",     32'(ba.w_en), 0);
    check("rst_idx0",     32'(ba.idx0), 0);
    check("rst_xr",       {16'd0, ba.xr}, 0);
    check("rst_xi",       {16'd0, ba.xi}, 0);
    check("rst_busy",     32'(busy_a), 0);
    check("rst_fft_done", 32'(done_a), 0);
    check("rst_err",      32'(err_a), 0);
    check("rst_s_ready",  32'(ba.s_ready), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("ready_low_before_edge", 32'(ba.s_ready), 0);
    @(posedge clk);
    #1 check("ready_after_rst", 32'(ba.s_ready), 1);

    // Single frame: re=k*1000, im=-k
    starts.delete();
    for (int k = 0; k < N; k++) send(16'(k * 1000), 16'(-k), k == N - 1);
    t = acc_cyc;
    idle();
    wait_done(1);
    check("t1_bursts", starts.size(), 1);
    check("t1_first_wen_lat", starts[0] - t, 1);
    check("t1_queue_drained", expq.size(), 0);
    check("t1_busy_after", 32'(busy_a), 0);

    // 24 continuous samples: three frames, throttled after 16
    starts.delete();
    stall_at = -1;
    n_acc = 0;
    d0 = n_done;
    for (int k = 0; k < 3 * N; k++) send(16'(100 + k), 16'(-200 - k), 1'b0);
    idle();
    wait_done(d0 + 3);
    check("t2_bursts", starts.size(), 3);
    check("t2_spacing1", starts[1] - starts[0], N + GAP + 1);
    check("t2_spacing2", starts[2] - starts[1], N + GAP + 1);
    check("t2_stall_at", stall_at, 2 * N);
    check("t2_queue_drained", expq.size(), 0);

    // Short frame: s_last on the 5th sample
    e0 = n_err_seen;
    d0 = n_done;
    for (int k = 0; k < 5; k++) send(16'h1111 * 16'(k + 1), 16'(k), k == 4);
    check("t3_err_pulse", 32'(err_a), 1);
    idle();
    @(posedge clk);
    #1 check("t3_err_single", 32'(err_a), 0);
    check("t3_no_burst", 32'(ba.w_en), 0);
    for (int k = 0; k < N; k++) send(16'(-5 * k - 3), 16'(7 * k), k == N - 1);
    idle();
    wait_done(d0 + 1);
    check("t3_err_count", n_err_seen - e0, 1);
    check("t3_queue_drained", expq.size(), 0);

    // Reset while idx0==3 of a burst
    for (int k = 0; k < N; k++) send(16'(k + 40), 16'(k + 50), 1'b0);
    idle();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (ba.w_en && ba.idx0 == 3) found = 1'b1;
    end
    check("t4_reach_idx3", 32'(found), 1);
    #1 rst = 1'b1;
    #1;
    check("t4_w_en_abort", 32'(ba.w_en), 0);
    check("t4_busy_abort", 32'(busy_a), 0);
    check("t4_idx0_abort", 32'(ba.idx0), 0);
    check("t4_ready_abort", 32'(ba.s_ready), 0);
    expq.delete();
    pend.delete();
    d0 = n_done;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1 check("t4_no_done", n_done, d0);
    for (int k = 0; k < N; k++) send(16'(900 + k), 16'(-900 - k), 1'b0);
    idle();
    wait_done(d0 + 1);
    check("t4_queue_drained", expq.size(), 0);

    // Extreme values with random s_valid gaps
    d0 = n_done;
    for (int k = 0; k < 2 * N; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        idle();
        @(posedge clk);
        #1;
      end
      re = (k % 2 == 1) ? 16'h8000 : 16'h7FFF;
      im = (k % 3 == 0) ? 16'h8000 : ((k % 5 == 0) ? 16'h0000 : 16'h7FFF);
      send(re, im, 1'b0);
    end
    idle();
    wait_done(d0 + 2);
    check("t5_queue_drained", expq.size(), 0);

    // N=4, GAP=1 instance
    for (int k = 0; k < 4; k++) begin
      bb.s_valid = 1'b1;
      bb.s_re    = 16'(k * 7 + 1);
      bb.s_im    = 16'(-(k * 7 + 1));
      bb.s_last  = (k == 3);
      @(negedge clk);
      check("t6_ready", 32'(bb.s_ready), 1);
      @(posedge clk);
      #1;
    end
    bb.s_valid = 1'b0;
    bb.s_last  = 1'b0;
    nw = 0;
    nd = 0;
    lastc = -100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bb.w_en) begin
        check("t6_idx0", 32'(bb.idx0), nw);
        check("t6_xr", {16'd0, bb.xr}, {16'd0, 16'(nw * 7 + 1)});
        check("t6_xi", {16'd0, bb.xi}, {16'd0, 16'(-(nw * 7 + 1))});
        nw++;
        lastc = cyc;
      end
      if (done_b) begin
        check("t6_done_lat", cyc - lastc, 1);
        nd++;
      end
    end
    check("t6_burst_len", nw, 4);
    check("t6_done_count", nd, 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_chk);
    $finish;
  end
endmodule
